mips_regfile_scoreboard: RTL

//  Parametrised GPR file with a write-pending scoreboard for the pipe_MIPS32 core.
//  - Sits between ID (issue/operand read) and WB (write-back).
//  - Stalls ID on RAW/WAW hazards, so programs no longer need dummy OR R7,R7,R7 fillers.
//  - Supports cycle-accurate write-through bypass and stall statistics.

---
 rtl/mips_regfile_scoreboard_if.sv | 53 +++++
 rtl/mips_regfile_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// mips_regfile_scoreboard_if
// Bundles the issue (ID), write-back (WB) and status signals of the GPR
// scoreboard so the core and the scoreboard connect through one port.
//   master : ID/WB side. Drives issue_* and wb_*, receives operands, stall
//            and status.
//   slave  : the scoreboard itself.
// Signals
//   issue_valid/rs/rt/rd/wr : instruction presented by ID
//   issue_stall/issue_fire  : hazard hold / instruction accepted
//   rs_data/rt_data         : operands, with write-through bypass
//   wb_valid/wb_rd/wb_data  : write-back port
//   pending_mask/cnt        : outstanding-write scoreboard state
//   stall_cnt, wdog_err     : statistics and watchdog flag
// ---------------------------------------------------------------------------
interface mips_regfile_scoreboard_if #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int STALL_W = 16
);
  localparam int AW = $clog2(NREGS);

  logic              issue_valid;
  logic [AW-1:0]     issue_rs;
  logic [AW-1:0]     issue_rt;
  logic [AW-1:0]     issue_rd;
  logic              issue_wr;
  logic              issue_stall;
  logic              issue_fire;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [NREGS-1:0]  pending_mask;
  logic [AW:0]       pending_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic              wdog_err;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_wr,
    output wb_valid, wb_rd, wb_data,
    input  issue_stall, issue_fire, rs_data, rt_data,
    input  pending_mask, pending_cnt, stall_cnt, wdog_err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_wr,
    input  wb_valid, wb_rd, wb_data,
    output issue_stall, issue_fire, rs_data, rt_data,
    output pending_mask, pending_cnt, stall_cnt, wdog_err
  );
endinterface

// File: rtl/mips_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// mips_regfile_scoreboard
// General-purpose register file with a write-pending scoreboard for the
// pipe_MIPS32 core. It sits between ID (operand read / issue) and WB, stalls
// ID on RAW and WAW hazards, bypasses same-cycle write-back data to the
// operand ports and keeps a saturating count of stalled cycles.
// Ports
//   clk1 : system clock, rising edge
//   rst  : synchronous active-high reset (clears registers and scoreboard)
//   sb   : mips_regfile_scoreboard_if.slave (issue, write-back and status)
// Optional feature
//   SB_WATCHDOG_EN : when defined, a per-register age counter flags
//                    (sticky wdog_err) any write left pending for WDOG_CYC
//                    cycles. When undefined no counters exist and wdog_err
//                    is tied low.
// ---------------------------------------------------------------------------
module mips_regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int STALL_W  = 16,
  parameter int WDOG_CYC = 64
) (
  input logic clk1,
  input logic rst,
  mips_regfile_scoreboard_if.slave sb
);
  localparam int AW = $clog2(NREGS);

  // Age counter type; sized to hold WDOG_CYC itself
  typedef logic [$clog2(WDOG_CYC+1)-1:0] wdogCnt_t;

  logic [DATA_W-1:0]  regFile_q [NREGS];
  logic [NREGS-1:0]   pendingMask_q, pendingMask_d;
  logic [AW:0]        pendingCnt_q, pendingCnt_d;
  logic [STALL_W-1:0] stallCnt_q, stallCnt_d;

  logic [NREGS-1:0]   wbHit;
  logic [NREGS-1:0]   effPending;
  logic [NREGS-1:0]   setVec;
  logic               stall;
  logic               fire;
  logic               rdIsZero;
  logic               wbIsZero;
  logic               rsBypass;
  logic               rtBypass;

  // Decode the write-back and issue destinations into one-hot vectors.
  // A write-back in this cycle releases the hazard on its register, so the
  // hazard check looks at the mask with that bit removed. A new producer
  // marks its destination pending; R0 never becomes pending when hard-wired.
  always_comb begin
    wbHit    = '0;
    setVec   = '0;
    rdIsZero = (ZERO_REG != 0) && (sb.issue_rd == '0);
    for (int r = 0; r < NREGS; r++) begin
      wbHit[r] = sb.wb_valid && (sb.wb_rd == AW'(r));
    end
    effPending = pendingMask_q & ~wbHit;
    stall = sb.issue_valid &&
            (effPending[sb.issue_rs] || effPending[sb.issue_rt] ||
             (sb.issue_wr && effPending[sb.issue_rd]));
    fire  = sb.issue_valid && !stall;
    for (int r = 0; r < NREGS; r++) begin
      setVec[r] = fire && sb.issue_wr && !rdIsZero && (sb.issue_rd == AW'(r));
    end
    // Set after clear: a same-cycle new producer keeps the bit pending
    pendingMask_d = (pendingMask_q & ~wbHit) | setVec;
  end

  // Pending count is the population count of the updated mask, so the
  // registered output follows the mask with the same one-cycle latency.
  always_comb begin
    pendingCnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      pendingCnt_d = pendingCnt_d + {{AW{1'b0}}, pendingMask_d[r]};
    end
  end

  // Stalled-cycle counter sticks at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  // Operand read with write-through bypass; a write-back aimed at the
  // hard-wired R0 must not leak through the bypass path.
  always_comb begin
    wbIsZero = (ZERO_REG != 0) && (sb.wb_rd == '0);
    rsBypass = sb.wb_valid && (sb.wb_rd == sb.issue_rs) && !wbIsZero;
    rtBypass = sb.wb_valid && (sb.wb_rd == sb.issue_rt) && !wbIsZero;
    sb.rs_data = rsBypass ? sb.wb_data : regFile_q[sb.issue_rs];
    sb.rt_data = rtBypass ? sb.wb_data : regFile_q[sb.issue_rt];
  end

  // Register file and scoreboard state. Reset wins over any same-cycle
  // issue or write-back, dropping writes that are still in flight.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regFile_q[r] <= '0;
      end
      pendingMask_q <= '0;
      pendingCnt_q  <= '0;
      stallCnt_q    <= '0;
    end else begin
      if (sb.wb_valid && !wbIsZero) begin
        regFile_q[sb.wb_rd] <= sb.wb_data;
      end
      pendingMask_q <= pendingMask_d;
      pendingCnt_q  <= pendingCnt_d;
      stallCnt_q    <= stallCnt_d;
    end
  end

`ifdef SB_WATCHDOG_EN
  wdogCnt_t wdogCnt_q [NREGS];
  logic     wdogErr_q;
  logic     wdogHit;

  // Any register whose age has reached the limit trips the watchdog.
  always_comb begin
    wdogHit = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (wdogCnt_q[r] == wdogCnt_t'(WDOG_CYC)) begin
        wdogHit = 1'b1;
      end
    end
  end

  // Per-register age: restarts at 0 whenever a new producer claims the
  // register, counts while the bit stays set, clears once it is released.
  // The flag is sticky until reset.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        wdogCnt_q[r] <= '0;
      end
      wdogErr_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (setVec[r]) begin
          wdogCnt_q[r] <= '0;
        end else if (pendingMask_q[r] && pendingMask_d[r]) begin
          if (wdogCnt_q[r] != wdogCnt_t'(WDOG_CYC)) begin
            wdogCnt_q[r] <= wdogCnt_q[r] + 1'b1;
          end
        end else begin
          wdogCnt_q[r] <= '0;
        end
      end
      if (wdogHit) begin
        wdogErr_q <= 1'b1;
      end
    end
  end

  assign sb.wdog_err = wdogErr_q;
`else
  assign sb.wdog_err = 1'b0;
`endif

  assign sb.issue_stall  = stall;
  assign sb.issue_fire   = fire;
  assign sb.pending_mask = pendingMask_q;
  assign sb.pending_cnt  = pendingCnt_q;
  assign sb.stall_cnt    = stallCnt_q;

endmodule
